timer_counter: RTL



---
 rtl/timer_counter_pkg.sv | 23 ++
 rtl/timer_counter.sv | 93 +++++++++
 2 files changed

// File: rtl/timer_counter_pkg.sv
// Shared register map, CTRL field positions and FSM state encodings for the countdown timer.
package timer_counter_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam int unsigned CTRL_W    = 4;
  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_MODE = 1;
  localparam int unsigned CTRL_IM   = 3;

  // Only 01 reloads; 00 and the reserved 1x codes run one-shot.
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: counts PRESET down to zero and raises IRQ,
// one-shot (level held until acknowledged) or auto-reload (1-cycle pulses).
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  logic [CTRL_W-1:0] ctrl;
  logic [WIDTH-1:0]  preset;
  logic [WIDTH-1:0]  count;
  logic              irq_flag;
  tc_state_e         state;

  logic ctrl_wr;
  logic preset_wr;
  logic enable;
  logic reload;

  assign ctrl_wr   = WE && (Addr == TC_CTRL);
  assign preset_wr = WE && (Addr == TC_PRESET);
  assign enable    = ctrl[CTRL_EN];
  assign reload    = (ctrl[CTRL_MODE +: 2] == MODE_RELOAD);

  assign IRQ = ctrl[CTRL_IM] & irq_flag;

  // Zero-latency read mux; the reserved offset reads as zero.
  always_comb begin
    DOut = 32'd0;
    case (Addr)
      TC_CTRL:   DOut = 32'(ctrl);
      TC_PRESET: DOut = 32'(preset);
      TC_COUNT:  DOut = 32'(count);
      default:   DOut = 32'd0;
    endcase
  end

  // Bus writes first, FSM updates after, so a flag set in CNT beats a same-cycle ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      if (ctrl_wr)   ctrl   <= DIn[CTRL_W-1:0];
      if (preset_wr) preset <= DIn[WIDTH-1:0];
      if (ctrl_wr || preset_wr) irq_flag <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (count > WIDTH'(1)) begin
            count <= count - WIDTH'(1);
          end else begin
            count    <= '0;
            irq_flag <= 1'b1;
            state    <= ST_INT;
          end
        end
        ST_INT: begin
          if (reload) begin
            irq_flag <= 1'b0;
            state    <= enable ? ST_LOAD : ST_IDLE;
          end else begin
            // A CPU CTRL write in this cycle keeps whatever Enable it wrote.
            if (!ctrl_wr) ctrl[CTRL_EN] <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
